// File: rtl/scr1_lsu_hs_burst_adapter_pkg.sv
// rtl/scr1_lsu_hs_burst_adapter_pkg.sv - shared memif types and constants for the highspeed LSU burst adapter
package scr1_lsu_hs_burst_adapter_pkg;

  localparam int SCR1_DMEM_AWIDTH   = 32;
  localparam int SCR1_HS_WORD_W     = 32;
  localparam int SCR1_HS_MAX_WORDS  = 5;
  localparam int YTYDLA_LSU_WIDTH   = SCR1_HS_WORD_W * SCR1_HS_MAX_WORDS;
  localparam int SCR1_HS_IDX_W      = 3;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_Y_WIDTH_FIVE_WORD  = 2'b00,
    SCR1_MEM_Y_WIDTH_THREE_WORD = 2'b01
  } type_scr1_mem_y_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [2:0] {
    HS_ST_IDLE  = 3'd0,
    HS_ST_ISSUE = 3'd1,
    HS_ST_WAIT  = 3'd2,
    HS_ST_DONE  = 3'd3,
    HS_ST_ERR   = 3'd4
  } type_scr1_hs_state_e;

  // Unknown width encodings fall back to the widest burst.
  function automatic logic [SCR1_HS_IDX_W-1:0] hs_word_count(input type_scr1_mem_y_width_e w);
    case (w)
      SCR1_MEM_Y_WIDTH_THREE_WORD: hs_word_count = 3'd3;
      default:                     hs_word_count = 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/scr1_lsu_hs_burst_adapter.sv
// rtl/scr1_lsu_hs_burst_adapter.sv - splits wide LSU requests into word-serial DMEM accesses
module scr1_lsu_hs_burst_adapter
  import scr1_lsu_hs_burst_adapter_pkg::*;
#(
  parameter int WORD_W    = SCR1_HS_WORD_W,
  parameter int MAX_WORDS = SCR1_HS_MAX_WORDS,
  parameter int AWIDTH    = SCR1_DMEM_AWIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hs_req,
  input  type_scr1_mem_cmd_e            hs_cmd,
  input  type_scr1_mem_y_width_e        hs_width,
  input  logic [AWIDTH-1:0]             hs_addr,
  input  logic [WORD_W*MAX_WORDS-1:0]   hs_wdata,
  output logic                          hs_req_ack,
  output logic [WORD_W*MAX_WORDS-1:0]   hs_rdata,
  output type_scr1_mem_resp_e           hs_resp,
  output logic                          dmem_req,
  output type_scr1_mem_cmd_e            dmem_cmd,
  output type_scr1_mem_width_e          dmem_width,
  output logic [AWIDTH-1:0]             dmem_addr,
  output logic [WORD_W-1:0]             dmem_wdata,
  input  logic                          dmem_req_ack,
  input  logic [WORD_W-1:0]             dmem_rdata,
  input  type_scr1_mem_resp_e           dmem_resp
);

  type_scr1_hs_state_e                         state, state_next;
  type_scr1_mem_cmd_e                          cmd_q;
  logic [AWIDTH-1:0]                           base_q;
  logic [MAX_WORDS-1:0][WORD_W-1:0]            wdata_q;
  logic [MAX_WORDS-1:0][WORD_W-1:0]            rbuf_q;
  logic [SCR1_HS_IDX_W-1:0]                    cnt_q;
  logic [SCR1_HS_IDX_W-1:0]                    idx_q;
  logic                                        word_last;
  logic                                        accept;
  logic                                        word_ok;

  assign word_last = (idx_q == (cnt_q - 3'd1));
  assign accept    = (state == HS_ST_IDLE) && hs_req;
  assign word_ok   = (state == HS_ST_WAIT) && (dmem_resp == SCR1_MEM_RESP_RDY_OK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HS_ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    hs_req_ack = 1'b0;
    hs_resp    = SCR1_MEM_RESP_NOTRDY;
    dmem_req   = 1'b0;
    case (state)
      HS_ST_IDLE: begin
        hs_req_ack = 1'b1;
        if (hs_req) begin
          state_next = (hs_addr[1:0] != 2'b00) ? HS_ST_ERR : HS_ST_ISSUE;
        end
      end
      HS_ST_ISSUE: begin
        dmem_req = 1'b1;
        if (dmem_req_ack) state_next = HS_ST_WAIT;
      end
      HS_ST_WAIT: begin
        if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
          state_next = word_last ? HS_ST_DONE : HS_ST_ISSUE;
        end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
          state_next = HS_ST_ERR;
        end
      end
      HS_ST_DONE: begin
        hs_resp    = SCR1_MEM_RESP_RDY_OK;
        state_next = HS_ST_IDLE;
      end
      HS_ST_ERR: begin
        hs_resp    = SCR1_MEM_RESP_RDY_ER;
        state_next = HS_ST_IDLE;
      end
      default: state_next = HS_ST_IDLE;
    endcase
  end

  // Buffer is cleared on accept, so unused lanes and store bursts read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= SCR1_MEM_CMD_RD;
      base_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      cmd_q   <= hs_cmd;
      base_q  <= hs_addr;
      wdata_q <= hs_wdata;
      rbuf_q  <= '0;
      cnt_q   <= hs_word_count(hs_width);
      idx_q   <= '0;
    end else if (word_ok) begin
      if (cmd_q == SCR1_MEM_CMD_RD) rbuf_q[idx_q] <= dmem_rdata;
      if (!word_last) idx_q <= idx_q + 3'd1;
    end
  end

  assign hs_rdata   = rbuf_q;
  assign dmem_cmd   = cmd_q;
  assign dmem_width = SCR1_MEM_WIDTH_WORD;
  assign dmem_addr  = base_q + AWIDTH'({idx_q, 2'b00});
  assign dmem_wdata = wdata_q[idx_q];

endmodule

// File: doc/scr1_lsu_hs_burst_adapter.md
# scr1_lsu_hs_burst_adapter

Splits each wide request from the highspeed LSU (five-word or three-word read/write) into a sequence of single-word accesses on the standard 32-bit data-memory port. It assembles the word responses into one wide response back to the LSU. The block sits directly downstream of the highspeed LSU and upstream of the DMEM router/TCM. It turns the LSU's one-shot wide handshake into a counted, word-serial transaction.

## Interface
- `WORD_W`, 32, width of one DMEM word.
- `MAX_WORDS`, 5, words per widest burst. The wide data width is `WORD_W*MAX_WORDS`, equal to `` `YTYDLA_LSU_WIDTH ``.
- `AWIDTH`, `` `SCR1_DMEM_AWIDTH ``, address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `hs_req`  in  1  wide request from the LSU.
- `hs_cmd`  in  `type_scr1_mem_cmd_e`  RD/WR.
- `hs_width`  in  `type_scr1_mem_y_width_e`  FIVE_WORD / THREE_WORD.
- `hs_addr`  in  AWIDTH  base byte address.
- `hs_wdata`  in  WORD_W*MAX_WORDS  store data; lane i = bits [32i+31:32i].
- `hs_req_ack`  out  1  request accepted.
- `hs_rdata`  out  WORD_W*MAX_WORDS  assembled load data.
- `hs_resp`  out  `type_scr1_mem_resp_e`  NOTRDY / RDY_OK / RDY_ER.
- `dmem_req`  out  1  word request.
- `dmem_cmd`  out  `type_scr1_mem_cmd_e`  word command.
- `dmem_width`  out  `type_scr1_mem_width_e`  constant `SCR1_MEM_WIDTH_WORD`.
- `dmem_addr`  out  AWIDTH  word address.
- `dmem_wdata`  out  WORD_W  word store data.
- `dmem_req_ack`  in  1  word request accepted.
- `dmem_rdata`  in  WORD_W  word load data.
- `dmem_resp`  in  `type_scr1_mem_resp_e`  word response.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE, ERR.
- **IDLE**
  - `hs_req_ack=1`.
  - On `hs_req`, capture cmd, base address, wdata and word count N (FIVE_WORD→5, THREE_WORD→3, any other encoding→5).
  - Clear the index i=0 and the read buffer.
  - If `hs_addr[1:0]!=0`, go to ERR with no DMEM access. Otherwise go to ISSUE.
- **ISSUE**
  - `dmem_req=1`, `dmem_addr=base+4*i` (modulo 2^AWIDTH), `dmem_cmd`=captured cmd, `dmem_wdata`=captured lane i.
  - On `dmem_req_ack`, go to WAIT. Otherwise hold, with all outputs stable.
- **WAIT**
  - On RDY_OK: for RD, write `dmem_rdata` into buffer lane i. If i==N-1, go to DONE; otherwise i++ and go to ISSUE.
  - On RDY_ER: go to ERR; the remaining words are not issued.
  - On NOTRDY: hold.
- **DONE:** `hs_resp=RDY_OK` for exactly one cycle, then IDLE.
- **ERR:** `hs_resp=RDY_ER` for exactly one cycle, then IDLE.
- **`hs_rdata`**
  - Driven from the buffer at all times.
  - Lanes ≥N read zero.
  - For WR, the whole buffer reads zero.
- **Outside DONE/ERR:** `hs_resp=NOTRDY`.
- **Ignored inputs:** `hs_req` outside IDLE (ack is 0). `dmem_resp` in IDLE, ISSUE, DONE or ERR.

## Timing
- **Reset values:** state IDLE, `hs_req_ack=1`, `hs_resp=NOTRDY`, `dmem_req=0`, `dmem_addr=0`, `dmem_wdata=0`, `dmem_cmd=RD`, `hs_rdata=0`, i=0.
- **Reset mid-burst:** abandons the transaction immediately. No response is produced and no further `dmem_req` is issued.
- **Zero-wait memory** (ack in the request cycle, response the next cycle), with the request accepted at T0:
  - Word i is requested at T1+2i and responded at T2+2i.
  - `hs_resp` is RDY_OK at T(2N+1): T11 for five words, T7 for three.
- **Misaligned base:** RDY_ER at T1 and `dmem_req` never asserted.
- **DMEM error on word k:** RDY_ER at T(2k+3).
- **Stalls:** each cycle of ack stall or resp NOTRDY adds one cycle.
- **Back-to-back:** `hs_req_ack` returns to 1 the cycle after DONE/ERR, so a new request can be accepted then.

## Structure
- Add `type_scr1_mem_y_width_e` (if not already shared) and the `MAX_WORDS` / lane-width constants to the shared memif header/package.
- Word count decode lives in that package as a function.
- Single module; no sub-module. The buffer and counter are small enough to stay inline.

## Test plan
- **Five-word read, zero-wait memory, base 0x100:**
  - Addresses 0x100, 0x104, 0x108, 0x10C, 0x110 are issued.
  - Words 0x11…0x55 are returned; `hs_rdata` lanes 0–4 hold 0x11…0x55.
  - RDY_OK at T11.
- **Three-word write, base 0x200:**
  - Three `dmem_req` with WR and lanes 0–2 of wdata.
  - RDY_OK at T7; `hs_rdata` = 0.
- **Base 0x202:** RDY_ER at T1; `dmem_req` stays 0 throughout.
- **Five-word read with RDY_ER on word 2:** exactly 3 word requests; RDY_ER at T7; IDLE at T8.
- **Stalls and busy request:**
  - `dmem_req_ack` low for 3 cycles on word 0: `dmem_addr` stable during the stall and RDY_OK delayed to T14.
  - `hs_req` held high during the burst is not acked.
- **Edge cases:**
  - Base 0xFFFF_FFF8, five words: addresses wrap to 0x0, 0x4, 0x8.
  - `rst_n` asserted during WAIT: all outputs take their reset values and no response follows.
